jtframe_sdram_arb: RTL and testbench

Sequences the single frame SDRAM read port (`sdram_req`/`sdram_addr`/`sdram_ack`/`data_rdy`/`data_read`) among N game-side ROM requesters. It sits between the game core's ROM slots and the frame SDRAM controller. Each slot has a one-entry hit buffer, so repeated reads of the same address skip the SDRAM. The block also drives `refresh_en` when the port is idle and gates all traffic while ROM download is active.

---
 rtl/jtframe_sdram_arb_pkg.sv | 12 +
 rtl/jtframe_sdram_arb_slot.sv | 45 ++++
 rtl/jtframe_sdram_arb.sv | 205 ++++++++++++++++++++
 tb/tb_jtframe_sdram_arb.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtframe_sdram_arb_pkg.sv
// Shared constants for the frame SDRAM read-port arbiter.
// States are plain localparam constants so that legacy code can compare them directly.
package jtframe_sdram_arb_pkg;

  localparam int unsigned N_MAX = 8;
  localparam int unsigned ST_W  = 2;

  localparam logic [ST_W-1:0] ST_IDLE     = 2'd0;
  localparam logic [ST_W-1:0] ST_WAIT_ACK = 2'd1;
  localparam logic [ST_W-1:0] ST_WAIT_RDY = 2'd2;

endpackage

// File: rtl/jtframe_sdram_arb_slot.sv
// One-entry hit buffer for a single ROM requester slot.
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   inv         : clear the valid bit (ROM download)
//   wr          : load wr_addr/wr_data and set valid
//   addr        : the slot's current request address
//   hit_c       : buffer valid and tag equals addr (combinational)
//   data        : buffered read data
module jtframe_sdram_arb_slot #(
  parameter int unsigned AW = 22,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inv,
  input  logic          wr,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] addr,
  output logic          hit_c,
  output logic [DW-1:0] data
);

  logic          valid;
  logic [AW-1:0] tag;

  // Invalidate wins over a write so a download always leaves the buffer empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      tag   <= '0;
      data  <= '0;
    end else begin
      if (inv)     valid <= 1'b0;
      else if (wr) valid <= 1'b1;
      if (wr) begin
        tag  <= wr_addr;
        data <= wr_data;
      end
    end
  end

  assign hit_c = valid && (tag == addr);

endmodule

// File: rtl/jtframe_sdram_arb.sv
// Arbitrates the single frame SDRAM read port among N ROM requester slots,
// with a one-entry hit buffer per slot.
// Optional feature: define JTFRAME_SDRAM_ARB_RR_EN for round-robin miss grant;
// otherwise misses are granted by fixed priority (lowest index).
// Ports:
//   clk, rst_n              : clock, async active-low reset
//   downloading             : ROM download active, blocks arbitration
//   slot_req/slot_addr      : per-slot request level and address (slot i at [i*AW +: AW])
//   slot_ok/slot_dout       : one-cycle data-valid pulse per slot, shared data bus
//   sdram_req/sdram_addr    : request to the SDRAM controller
//   sdram_ack/data_rdy/data_read : controller handshake and read data
//   refresh_en              : controller may refresh
module jtframe_sdram_arb
  import jtframe_sdram_arb_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned AW = 22,
  parameter int unsigned DW = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            downloading,
  input  logic [N-1:0]    slot_req,
  input  logic [N*AW-1:0] slot_addr,
  output logic [N-1:0]    slot_ok,
  output logic [DW-1:0]   slot_dout,
  output logic            sdram_req,
  output logic [AW-1:0]   sdram_addr,
  input  logic            sdram_ack,
  input  logic            data_rdy,
  input  logic [DW-1:0]   data_read,
  output logic            refresh_en
);

  localparam int unsigned GW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned NS = (N > N_MAX) ? N_MAX : N;

  logic [ST_W-1:0] state, state_n;
  logic [GW-1:0]   grant, grant_n;
  logic            abort, abort_n;
  logic            sdram_req_n;
  logic [AW-1:0]   sdram_addr_n;
  logic [N-1:0]    slot_ok_n;
  logic [DW-1:0]   slot_dout_n;
  logic            refresh_en_n;

  logic            inv_c, wr_c, do_rdy_c;
  logic            hit_found_c, miss_found_c;
  logic [GW-1:0]   hit_idx_c, miss_idx_c;
  logic [N-1:0]    hit_c, elig_c;
  logic [AW-1:0]   req_addr [N];
  logic [DW-1:0]   buf_data [N];

  // A slot just served is masked for one cycle so a held request is not re-served.
  assign elig_c = slot_req & ~slot_ok;

  for (genvar gi = 0; gi < N; gi++) begin : g_slot
    assign req_addr[gi] = slot_addr[gi*AW +: AW];

    jtframe_sdram_arb_slot #(.AW(AW), .DW(DW)) u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .inv     (inv_c),
      .wr      (wr_c && (grant == GW'(gi))),
      .wr_addr (sdram_addr),
      .wr_data (data_read),
      .addr    (req_addr[gi]),
      .hit_c   (hit_c[gi]),
      .data    (buf_data[gi])
    );
  end

`ifdef JTFRAME_SDRAM_ARB_RR_EN
  // Next slot to search from; advances only on an SDRAM grant.
  logic [GW-1:0] rr_ptr, rr_ptr_n;
  logic [GW-1:0] rr_idx_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ptr <= '0;
    else        rr_ptr <= rr_ptr_n;
  end
`endif

  // Hit and miss selection; loops run downwards so the lowest candidate wins.
  always_comb begin
    hit_found_c  = 1'b0;
    hit_idx_c    = '0;
    miss_found_c = 1'b0;
    miss_idx_c   = '0;
    for (int i = NS - 1; i >= 0; i--) begin
      if (elig_c[i] && hit_c[i]) begin
        hit_found_c = 1'b1;
        hit_idx_c   = GW'(i);
      end
    end
`ifdef JTFRAME_SDRAM_ARB_RR_EN
    rr_idx_c = '0;
    for (int k = NS - 1; k >= 0; k--) begin
      rr_idx_c = GW'((int'(rr_ptr) + k) % int'(NS));
      if (elig_c[rr_idx_c]) begin
        miss_found_c = 1'b1;
        miss_idx_c   = rr_idx_c;
      end
    end
`else
    for (int i = NS - 1; i >= 0; i--) begin
      if (elig_c[i]) begin
        miss_found_c = 1'b1;
        miss_idx_c   = GW'(i);
      end
    end
`endif
  end

  // Next-state and output logic.
  always_comb begin
    state_n      = state;
    grant_n      = grant;
    abort_n      = abort;
    sdram_req_n  = sdram_req;
    sdram_addr_n = sdram_addr;
    slot_ok_n    = '0;
    slot_dout_n  = slot_dout;
    refresh_en_n = downloading || ((state == ST_IDLE) && (elig_c == '0));
    inv_c        = 1'b0;
    wr_c         = 1'b0;
    do_rdy_c     = 1'b0;
`ifdef JTFRAME_SDRAM_ARB_RR_EN
    rr_ptr_n     = rr_ptr;
`endif

    case (state)
      ST_IDLE: begin
        if (downloading) begin
          inv_c = 1'b1;
        end else if (hit_found_c) begin
          slot_ok_n   = N'(1) << hit_idx_c;
          slot_dout_n = buf_data[hit_idx_c];
        end else if (miss_found_c) begin
          grant_n      = miss_idx_c;
          sdram_addr_n = req_addr[miss_idx_c];
          sdram_req_n  = 1'b1;
          abort_n      = 1'b0;
          state_n      = ST_WAIT_ACK;
`ifdef JTFRAME_SDRAM_ARB_RR_EN
          rr_ptr_n = (miss_idx_c == GW'(NS - 1)) ? '0 : GW'(miss_idx_c + GW'(1));
`endif
        end
      end
      ST_WAIT_ACK: begin
        if (downloading) abort_n = 1'b1;
        if (sdram_ack) begin
          sdram_req_n = 1'b0;
          // Ack and ready together: finish the read in the same cycle.
          do_rdy_c    = data_rdy;
          state_n     = data_rdy ? ST_IDLE : ST_WAIT_RDY;
        end
      end
      ST_WAIT_RDY: begin
        if (downloading) abort_n = 1'b1;
        if (data_rdy) begin
          do_rdy_c = 1'b1;
          state_n  = ST_IDLE;
        end
      end
      default: begin
        sdram_req_n = 1'b0;
        state_n     = ST_IDLE;
      end
    endcase

    // A download during the access discards the data entirely; a request that
    // dropped or moved address still fills the buffer but gets no pulse.
    if (do_rdy_c && !abort && !downloading) begin
      wr_c = 1'b1;
      if (slot_req[grant] && (req_addr[grant] == sdram_addr)) begin
        slot_ok_n   = N'(1) << grant;
        slot_dout_n = data_read;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      grant      <= '0;
      abort      <= 1'b0;
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
      slot_ok    <= '0;
      slot_dout  <= '0;
      refresh_en <= 1'b0;
    end else begin
      state      <= state_n;
      grant      <= grant_n;
      abort      <= abort_n;
      sdram_req  <= sdram_req_n;
      sdram_addr <= sdram_addr_n;
      slot_ok    <= slot_ok_n;
      slot_dout  <= slot_dout_n;
      refresh_en <= refresh_en_n;
    end
  end

endmodule

// File: tb/tb_jtframe_sdram_arb.sv
// Self-checking bench for jtframe_sdram_arb: directed requests, a scripted SDRAM
// controller, and a scoreboard of expected slot_ok/slot_dout pairs.
module tb_jtframe_sdram_arb;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 22;
  localparam int unsigned DW = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            downloading = 1'b0;
  logic [N-1:0]    slot_req = '0;
  logic [N*AW-1:0] slot_addr = '0;
  logic [N-1:0]    slot_ok;
  logic [DW-1:0]   slot_dout;
  logic            sdram_req;
  logic [AW-1:0]   sdram_addr;
  logic            sdram_ack = 1'b0;
  logic            data_rdy = 1'b0;
  logic [DW-1:0]   data_read = '0;
  logic            refresh_en;

  jtframe_sdram_arb #(.N(N), .AW(AW), .DW(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .downloading (downloading),
    .slot_req    (slot_req),
    .slot_addr   (slot_addr),
    .slot_ok     (slot_ok),
    .slot_dout   (slot_dout),
    .sdram_req   (sdram_req),
    .sdram_addr  (sdram_addr),
    .sdram_ack   (sdram_ack),
    .data_rdy    (data_rdy),
    .data_read   (data_read),
    .refresh_en  (refresh_en)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          slot;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    slot_addr[i*AW +: AW] = a;
  endtask

  function automatic exp_t mk(input int s, input logic [31:0] d);
    exp_t e;
    e.slot = s;
    e.data = d;
    return e;
  endfunction

  // Scoreboard monitor: every slot_ok pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && (slot_ok !== '0)) begin
      check("ok_onehot", 64'($countones(slot_ok)), 64'd1);
      if (q.size() == 0) begin
        check("unexpected_ok", 64'(slot_ok), 64'd0);
      end else begin
        mon_e = q.pop_front();
        check("ok_slot", 64'(slot_ok), 64'd1 << mon_e.slot);
        check("ok_data", 64'(slot_dout), 64'(mon_e.data));
      end
    end
  end

  // Scripted controller: wait for sdram_req, ack after ack_dly cycles, then data
  // after rdy_dly cycles (rdy_dly < 0: ready in the same cycle as ack).
  // Returns at the negedge where a resulting slot_ok is visible.
  task automatic serve(input logic [AW-1:0] exp_addr, input int ack_dly,
                       input int rdy_dly, input logic [31:0] d, input bit dl);
    int cnt;
    cnt = 0;
    while (!sdram_req && cnt < 50) begin
      tick();
      cnt++;
    end
    check("req_seen", 64'(sdram_req), 64'd1);
    if (!sdram_req) return;
    check("req_addr", 64'(sdram_addr), 64'(exp_addr));
    repeat (ack_dly) begin
      tick();
      check("req_hold", 64'(sdram_req), 64'd1);
    end
    sdram_ack = 1'b1;
    if (rdy_dly < 0) begin
      data_rdy  = 1'b1;
      data_read = d;
    end
    tick();
    sdram_ack = 1'b0;
    data_rdy  = 1'b0;
    data_read = '0;
    check("req_clr", 64'(sdram_req), 64'd0);
    if (rdy_dly >= 0) begin
      if (dl) downloading = 1'b1;
      repeat (rdy_dly) begin
        tick();
        if (dl) check("refresh_dl", 64'(refresh_en), 64'd1);
      end
      data_rdy  = 1'b1;
      data_read = d;
      tick();
      data_rdy  = 1'b0;
      data_read = '0;
    end
  endtask

  initial begin
    // Reset with every slot requesting.
    slot_req = 4'b1111;
    set_addr(0, 22'h00010);
    set_addr(1, 22'h00011);
    set_addr(2, 22'h00012);
    set_addr(3, 22'h00013);
    repeat (3) tick();
    check("rst_sdram_req", 64'(sdram_req), 64'd0);
    check("rst_sdram_addr", 64'(sdram_addr), 64'd0);
    check("rst_slot_ok", 64'(slot_ok), 64'd0);
    check("rst_slot_dout", 64'(slot_dout), 64'd0);
    check("rst_refresh", 64'(refresh_en), 64'd0);
    rst_n = 1'b1;
    tick();
    check("rst_first_req", 64'(sdram_req), 64'd1);
    q.push_back(mk(0, 32'h0000AAAA));
    serve(22'h00010, 1, 2, 32'h0000AAAA, 1'b0);
    slot_req = '0;
    tick();
    tick();
    check("idle_refresh", 64'(refresh_en), 64'd1);
    check("idle_no_req", 64'(sdram_req), 64'd0);

    // Single miss on slot 2.
    set_addr(2, 22'h01234);
    q.push_back(mk(2, 32'hDEADBEEF));
    slot_req[2] = 1'b1;
    serve(22'h01234, 3, 5, 32'hDEADBEEF, 1'b0);
    check("miss_ok", 64'(slot_ok), 64'h4);
    slot_req[2] = 1'b0;
    tick();
    check("miss_ok_single", 64'(slot_ok), 64'h0);

    // Repeat of the same address hits the buffer one cycle later.
    q.push_back(mk(2, 32'hDEADBEEF));
    slot_req[2] = 1'b1;
    tick();
    check("hit_ok", 64'(slot_ok), 64'h4);
    check("hit_no_sdram", 64'(sdram_req), 64'd0);
    slot_req[2] = 1'b0;
    tick();
    check("hit_no_sdram2", 64'(sdram_req), 64'd0);

    // New address on slot 2 misses.
    set_addr(2, 22'h01235);
    q.push_back(mk(2, 32'h12350002));
    slot_req[2] = 1'b1;
    serve(22'h01235, 1, 1, 32'h12350002, 1'b0);
    slot_req[2] = 1'b0;
    tick();

    // Slot 3 miss; leaves the round-robin search starting at slot 0.
    set_addr(3, 22'h00333);
    q.push_back(mk(3, 32'h33330003));
    slot_req[3] = 1'b1;
    serve(22'h00333, 1, 1, 32'h33330003, 1'b0);
    slot_req[3] = 1'b0;
    tick();

    // Contention: all four slots miss together.
    set_addr(0, 22'h00400);
    set_addr(1, 22'h00100);
    set_addr(2, 22'h00200);
    set_addr(3, 22'h00300);
    slot_req = 4'b1111;
`ifdef JTFRAME_SDRAM_ARB_RR_EN
    q.push_back(mk(0, 32'hC0000000));
    serve(22'h00400, 1, 1, 32'hC0000000, 1'b0);
    slot_req[0] = 1'b0;
    q.push_back(mk(1, 32'hC0000001));
    serve(22'h00100, 1, 1, 32'hC0000001, 1'b0);
    slot_req[1] = 1'b0;
    q.push_back(mk(2, 32'hC0000002));
    serve(22'h00200, 1, 1, 32'hC0000002, 1'b0);
    slot_req[2] = 1'b0;
    q.push_back(mk(3, 32'hC0000003));
    serve(22'h00300, 1, 1, 32'hC0000003, 1'b0);
    slot_req[3] = 1'b0;
`else
    // Slot 0 re-requests after each ok and wins every arbitration it enters.
    q.push_back(mk(0, 32'hC0000000));
    serve(22'h00400, 1, 1, 32'hC0000000, 1'b0);
    slot_req[0] = 1'b0;
    tick();
    set_addr(0, 22'h00401);
    slot_req[0] = 1'b1;
    q.push_back(mk(1, 32'hC0000001));
    serve(22'h00100, 1, 1, 32'hC0000001, 1'b0);
    slot_req[1] = 1'b0;
    q.push_back(mk(0, 32'hC0000010));
    serve(22'h00401, 1, 1, 32'hC0000010, 1'b0);
    slot_req[0] = 1'b0;
    q.push_back(mk(2, 32'hC0000002));
    serve(22'h00200, 1, 1, 32'hC0000002, 1'b0);
    slot_req[2] = 1'b0;
    q.push_back(mk(3, 32'hC0000003));
    serve(22'h00300, 1, 1, 32'hC0000003, 1'b0);
    slot_req[3] = 1'b0;
`endif
    tick();

    // Slot 3 buffer now holds 0x300: hit.
    q.push_back(mk(3, 32'hC0000003));
    slot_req[3] = 1'b1;
    tick();
    check("hit3_ok", 64'(slot_ok), 64'h8);
    slot_req[3] = 1'b0;
    tick();

    // Download rising mid-read: access completes silently.
    set_addr(1, 22'h00555);
    slot_req[1] = 1'b1;
    serve(22'h00555, 1, 3, 32'hBAD00001, 1'b1);
    check("dl_no_ok", 64'(slot_ok), 64'd0);
    slot_req[1] = 1'b0;
    repeat (3) begin
      tick();
      check("dl_refresh", 64'(refresh_en), 64'd1);
      check("dl_no_req", 64'(sdram_req), 64'd0);
    end
    downloading = 1'b0;
    tick();

    // Former hit address must now go to SDRAM.
    q.push_back(mk(3, 32'h30000003));
    slot_req[3] = 1'b1;
    serve(22'h00300, 1, 1, 32'h30000003, 1'b0);
    slot_req[3] = 1'b0;
    tick();

    // Ack and data ready in the same cycle.
    set_addr(0, 22'h00777);
    q.push_back(mk(0, 32'h77770000));
    slot_req[0] = 1'b1;
    serve(22'h00777, 2, -1, 32'h77770000, 1'b0);
    check("same_cycle_ok", 64'(slot_ok), 64'h1);
    slot_req[0] = 1'b0;
    repeat (3) tick();
    check("same_cycle_no_req", 64'(sdram_req), 64'd0);
    check("same_cycle_refresh", 64'(refresh_en), 64'd1);

    repeat (3) tick();
    check("sb_empty", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
